retire_trace_buffer: RTL and testbench

// - Captures the retire interface of rv_pipelined on every update pulse and queues one record per retired instruction.
// - Records are held in a DEPTH-entry FIFO and serialised as 32-bit packets onto a valid/ready trace stream for the TB or a debug UART.
// - The core cannot be back-pressured, so records that arrive when the FIFO is full are dropped and counted.

---
 rtl/retire_trace_buffer.sv | 172 +++++++++++++++++
 tb/tb_retire_trace_buffer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/retire_trace_buffer.sv
// Retire trace buffer: captures one record per retired instruction into a
// small FIFO and streams each record as a 3..6 word packet on a valid/ready
// trace port. The core cannot be stalled, so retires that find the FIFO full
// are dropped. A gap in the header sequence number shows where a drop happened.
//
// state  | meaning
// -------+-------------------------------------------------
// IDLE   | nothing to send, t_valid_o low
// HDR    | header word {seq, rv, wrt, rd, reg_addr, 16'h0}
// PC     | retired PC
// INSTR  | retired instruction
// RD     | rd write data (only when reg_addr != 0)
// MADDR  | memory address (only for loads/stores)
// MDATA  | memory data (only for loads/stores)
module retire_trace_buffer #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            trace_en_i,
    input  logic            clr_i,
    input  logic            update_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic [4:0]      reg_addr_i,
    input  logic [XLEN-1:0] reg_data_i,
    input  logic [XLEN-1:0] mem_addr_i,
    input  logic [XLEN-1:0] mem_data_i,
    input  logic            mem_wrt_i,
    input  logic            mem_read_i,
    output logic            t_valid_o,
    input  logic            t_ready_i,
    output logic [31:0]     t_data_o,
    output logic            t_last_o,
    output logic            overflow_o,
    output logic [15:0]     drop_cnt_o,
    output logic [31:0]     retire_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef struct packed {
        logic [7:0]      seq;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [4:0]      reg_addr;
        logic [XLEN-1:0] reg_data;
        logic [XLEN-1:0] mem_addr;
        logic [XLEN-1:0] mem_data;
        logic            wrt;
        logic            rd;
    } rec_t;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_PC, S_INSTR, S_RD, S_MADDR, S_MDATA
    } state_t;

    rec_t            mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr, count;
    logic [7:0]      seq;
    state_t          state, state_next;
    rec_t            head;
    logic            full, empty, capture, push, pop, hs;
    logic            rv, mem_op, more;

    // Occupancy is taken from registered pointers; a pop in the same cycle
    // does not free space for a concurrent capture.
    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == PW'(DEPTH));
    assign empty   = (count == '0);
    assign capture = update_i && trace_en_i;
    assign push    = capture && !full;
    assign hs      = t_valid_o && t_ready_i;
    assign pop     = hs && t_last_o;
    assign head    = mem[rd_ptr[AW-1:0]];
    assign rv      = (head.reg_addr != 5'd0);
    assign mem_op  = head.wrt | head.rd;
    // Another record is present once the head is gone, including one landing now.
    assign more    = (count > PW'(1)) || push;

    // Record storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk_i) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= '{seq: seq, pc: pc_i, instr: instr_i,
                                     reg_addr: reg_addr_i, reg_data: reg_data_i,
                                     mem_addr: mem_addr_i, mem_data: mem_data_i,
                                     wrt: mem_wrt_i, rd: mem_read_i};
    end

    // FIFO pointers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Sequence and statistics; clear wins over a concurrent increment.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            seq          <= '0;
            retire_cnt_o <= '0;
            drop_cnt_o   <= '0;
            overflow_o   <= 1'b0;
        end else if (clr_i) begin
            seq          <= '0;
            retire_cnt_o <= '0;
            drop_cnt_o   <= '0;
            overflow_o   <= 1'b0;
        end else if (capture) begin
            seq          <= seq + 8'd1;
            retire_cnt_o <= retire_cnt_o + 32'd1;
            if (full) begin
                overflow_o <= 1'b1;
                if (drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
            end
        end
    end

    // Packet FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next state: advance on handshake, skipping words the record lacks.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (!empty) state_next = S_HDR;
            S_HDR:   if (hs) state_next = S_PC;
            S_PC:    if (hs) state_next = S_INSTR;
            S_INSTR: if (hs) state_next = rv ? S_RD :
                                          (mem_op ? S_MADDR : (more ? S_HDR : S_IDLE));
            S_RD:    if (hs) state_next = mem_op ? S_MADDR : (more ? S_HDR : S_IDLE);
            S_MADDR: if (hs) state_next = S_MDATA;
            S_MDATA: if (hs) state_next = more ? S_HDR : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Stream outputs, driven from the FIFO head so they hold under back-pressure.
    always_comb begin
        t_valid_o = (state != S_IDLE);
        t_data_o  = 32'h0;
        t_last_o  = 1'b0;
        case (state)
            S_HDR:   t_data_o = {head.seq, rv, head.wrt, head.rd, head.reg_addr, 16'h0};
            S_PC:    t_data_o = head.pc;
            S_INSTR: begin
                t_data_o = head.instr;
                t_last_o = !rv && !mem_op;
            end
            S_RD: begin
                t_data_o = head.reg_data;
                t_last_o = !mem_op;
            end
            S_MADDR: t_data_o = head.mem_addr;
            S_MDATA: begin
                t_data_o = head.mem_data;
                t_last_o = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Directed bench for retire_trace_buffer with a queue-based packet model.
module tb_retire_trace_buffer;

    localparam int DEPTH = 8;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        trace_en_i, clr_i, update_i;
    logic [31:0] pc_i, instr_i, reg_data_i, mem_addr_i, mem_data_i;
    logic [4:0]  reg_addr_i;
    logic        mem_wrt_i, mem_read_i;
    logic        t_valid_o, t_ready_i, t_last_o, overflow_o;
    logic [31:0] t_data_o, retire_cnt_o;
    logic [15:0] drop_cnt_o;

    int vectors = 0;
    int errs    = 0;

    // Model state
    logic [31:0] wq[$];
    int          plen[$];
    bit          m_active;
    int          m_ret, m_drop;
    bit          m_ovf;
    logic [7:0]  m_seq;

    logic [31:0] log_q[$];

    retire_trace_buffer #(.XLEN(32), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .trace_en_i(trace_en_i), .clr_i(clr_i),
        .update_i(update_i), .pc_i(pc_i), .instr_i(instr_i),
        .reg_addr_i(reg_addr_i), .reg_data_i(reg_data_i),
        .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
        .mem_wrt_i(mem_wrt_i), .mem_read_i(mem_read_i),
        .t_valid_o(t_valid_o), .t_ready_i(t_ready_i), .t_data_o(t_data_o),
        .t_last_o(t_last_o), .overflow_o(overflow_o),
        .drop_cnt_o(drop_cnt_o), .retire_cnt_o(retire_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pkt_len(input logic [31:0] hdr);
        return 3 + int'(hdr[23]) + 2 * int'(hdr[22] | hdr[21]);
    endfunction

    // Reference model: one packet per accepted record, words popped per handshake.
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wq.delete(); plen.delete();
            m_active = 0; m_ret = 0; m_drop = 0; m_ovf = 0; m_seq = 0;
        end else begin
            int  occ;
            bit  last;
            occ  = plen.size();
            last = 0;
            if (m_active && t_ready_i) begin
                void'(wq.pop_front());
                plen[0] = plen[0] - 1;
                if (plen[0] == 0) begin
                    void'(plen.pop_front());
                    last = 1;
                end
            end
            if (update_i && trace_en_i) begin
                if (occ < DEPTH) begin
                    bit rv;
                    int n;
                    rv = (reg_addr_i != 0);
                    wq.push_back({m_seq, rv, mem_wrt_i, mem_read_i, reg_addr_i, 16'h0});
                    wq.push_back(pc_i);
                    wq.push_back(instr_i);
                    n = 3;
                    if (rv) begin wq.push_back(reg_data_i); n++; end
                    if (mem_wrt_i | mem_read_i) begin
                        wq.push_back(mem_addr_i); wq.push_back(mem_data_i); n += 2;
                    end
                    plen.push_back(n);
                end else begin
                    m_ovf = 1;
                    if (m_drop < 65535) m_drop++;
                end
                m_ret++;
                m_seq = m_seq + 8'd1;
            end
            if (clr_i) begin
                m_ret = 0; m_drop = 0; m_ovf = 0; m_seq = 0;
            end
            if (m_active) begin
                if (last) m_active = (plen.size() > 0);
            end else begin
                m_active = (occ > 0);
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            chk("t_valid", {31'b0, t_valid_o}, {31'b0, m_active});
            if (m_active && wq.size() > 0) begin
                chk("t_data", t_data_o, wq[0]);
                chk("t_last", {31'b0, t_last_o}, {31'b0, plen[0] == 1});
            end
            chk("overflow", {31'b0, overflow_o}, {31'b0, m_ovf});
            chk("drop_cnt", {16'b0, drop_cnt_o}, m_drop);
            chk("retire_cnt", retire_cnt_o, m_ret);
            if (t_valid_o && t_ready_i) log_q.push_back(t_data_o);
        end
    end

    task automatic retire(input logic [31:0] pc, input logic [31:0] instr,
                          input logic [4:0] ra, input logic [31:0] rdata,
                          input logic [31:0] maddr, input logic [31:0] mdata,
                          input logic w, input logic r);
        pc_i = pc; instr_i = instr; reg_addr_i = ra; reg_data_i = rdata;
        mem_addr_i = maddr; mem_data_i = mdata; mem_wrt_i = w; mem_read_i = r;
        update_i = 1'b1;
        @(posedge clk_i); #1;
        update_i = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_i = 1'b1;
        @(posedge clk_i); #1;
        clr_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((t_valid_o || wq.size() != 0) && n < 300) begin
            @(posedge clk_i); #1;
            n++;
        end
        vectors++;
        if (n >= 300) begin
            errs++;
            $display("FAIL drain_timeout: got %0d cycles expected <300", n);
        end
    endtask

    initial begin
        logic [31:0] exp1 [4];
        int idx;
        rst_i = 1'b1; trace_en_i = 1'b1; clr_i = 1'b0; update_i = 1'b0;
        pc_i = 0; instr_i = 0; reg_addr_i = 0; reg_data_i = 0;
        mem_addr_i = 0; mem_data_i = 0; mem_wrt_i = 0; mem_read_i = 0;
        t_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(posedge clk_i); #1;
        chk("rst_valid", {31'b0, t_valid_o}, 32'd0);
        chk("rst_retire", retire_cnt_o, 32'd0);
        chk("rst_drop", {16'b0, drop_cnt_o}, 32'd0);

        // ALU retire
        exp1 = '{32'h00810000, 32'h100, 32'h00500093, 32'h5};
        t_ready_i = 1'b1;
        log_q.delete();
        retire(32'h100, 32'h00500093, 5'd1, 32'd5, 32'h0, 32'h0, 1'b0, 1'b0);
        drain();
        chk("alu_len", log_q.size(), 32'd4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) chk("alu_word", log_q[i], exp1[i]);

        // Store retire with rd=0
        pulse_clr();
        log_q.delete();
        retire(32'h104, 32'h0AB12023, 5'd0, 32'd0, 32'h2000, 32'hAB, 1'b1, 1'b0);
        drain();
        chk("st_len", log_q.size(), 32'd5);
        if (log_q.size() == 5) begin
            chk("st_hdr", log_q[0], 32'h00400000);
            chk("st_pc", log_q[1], 32'h104);
            chk("st_maddr", log_q[3], 32'h2000);
            chk("st_mdata", log_q[4], 32'hAB);
        end

        // Back-pressure during PC word
        log_q.delete();
        retire(32'h200, 32'h00700113, 5'd2, 32'd7, 32'h0, 32'h0, 1'b0, 1'b0);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        t_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {31'b0, t_valid_o}, 32'd1);
            chk("stall_data", t_data_o, 32'h200);
            @(posedge clk_i); #1;
        end
        t_ready_i = 1'b1;
        drain();
        chk("stall_len", log_q.size(), 32'd4);
        if (log_q.size() == 4) begin
            chk("stall_hdr", log_q[0], 32'h01820000);
            chk("stall_pc", log_q[1], 32'h200);
            chk("stall_rd", log_q[3], 32'd7);
        end

        // Overflow: 10 retires against a stalled sink
        pulse_clr();
        t_ready_i = 1'b0;
        for (int i = 0; i < 10; i++)
            retire(32'h1000 + 4 * i, 32'h13 + i, 5'(i % 4), 32'(i * 3),
                   32'h3000 + i, 32'h50 + i, 1'(i % 3 == 1), 1'(i % 3 == 2));
        chk("ovf_flag", {31'b0, overflow_o}, 32'd1);
        chk("ovf_drop", {16'b0, drop_cnt_o}, 32'd2);
        chk("ovf_retire", retire_cnt_o, 32'd10);
        log_q.delete();
        t_ready_i = 1'b1;
        drain();
        idx = 0;
        for (int k = 0; k < 8; k++) begin
            if (idx < log_q.size()) begin
                chk("ovf_seq", {24'b0, log_q[idx][31:24]}, k);
                idx += pkt_len(log_q[idx]);
            end
        end
        chk("ovf_words", log_q.size(), idx);

        // Clear after overflow
        pulse_clr();
        log_q.delete();
        retire(32'h300, 32'h00100093, 5'd1, 32'd1, 32'h0, 32'h0, 1'b0, 1'b0);
        drain();
        chk("clr_ovf", {31'b0, overflow_o}, 32'd0);
        chk("clr_drop", {16'b0, drop_cnt_o}, 32'd0);
        chk("clr_retire", retire_cnt_o, 32'd1);
        if (log_q.size() > 0) chk("clr_seq", {24'b0, log_q[0][31:24]}, 32'd0);
        else chk("clr_len", log_q.size(), 32'd4);

        // trace_en dropped with packets queued: they still drain
        t_ready_i = 1'b0;
        retire(32'h400, 32'h1, 5'd0, 32'd0, 32'h0, 32'h0, 1'b0, 1'b0);
        retire(32'h404, 32'h2, 5'd0, 32'd0, 32'h40, 32'h9, 1'b0, 1'b1);
        trace_en_i = 1'b0;
        log_q.delete();
        retire(32'h408, 32'h3, 5'd3, 32'd3, 32'h0, 32'h0, 1'b0, 1'b0);
        t_ready_i = 1'b1;
        drain();
        chk("en_words", log_q.size(), 32'd8);
        chk("en_retire", retire_cnt_o, 32'd3);
        trace_en_i = 1'b1;

        // Reset mid-packet
        retire(32'h500, 32'h5, 5'd4, 32'd4, 32'h0, 32'h0, 1'b0, 1'b0);
        @(posedge clk_i); #1;
        @(posedge clk_i); #2;
        rst_i = 1'b1;
        #1;
        chk("rst_mid_valid", {31'b0, t_valid_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        log_q.delete();
        retire(32'h100, 32'h00500093, 5'd1, 32'd5, 32'h0, 32'h0, 1'b0, 1'b0);
        drain();
        chk("rst_len", log_q.size(), 32'd4);
        if (log_q.size() > 0) chk("rst_hdr", log_q[0], 32'h00810000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
